// File: rtl/pcm_capture.sv
// ---------------------------------------------------------------------------
// pcm_capture
//
// Audio capture path. It samples the mixer's signed 16-bit stereo output at a
// programmable rate and packs each frame into bytes in the layout that PCM
// playback consumes. The bytes go into an internal byte FIFO, which the host
// drains through fifo_read / fifo_rddata.
//
// Parameters:
//   DEPTH        FIFO size in bytes (power of two, >= 8)
//   ALMOST_FULL  fifo_almost_full threshold (fifo_count >= ALMOST_FULL)
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   next_sample       single-cycle base-rate tick
//   sample_rate[7:0]  rate accumulator increment (0 stops, 128 = every tick)
//   mode_stereo       1 = left+right, 0 = left only
//   mode_16bit        1 = 16-bit samples, 0 = 8-bit samples
//   capture_en        allows new frames to start
//   left_in/right_in  signed 16-bit sources
//   fifo_reset        synchronous FIFO clear (also aborts a frame)
//   fifo_read         host pop request
//   fifo_rddata[7:0]  popped byte, valid the cycle after fifo_read
//   fifo_empty/almost_full/full, fifo_count   registered FIFO status
//   overflow          sticky: at least one frame dropped
//
// Build option:
//   PCM_CAPTURE_ROUND_EN  when defined, an 8-bit sample is rounded from the
//                         16-bit source with saturation instead of truncated.
// ---------------------------------------------------------------------------
module pcm_capture #(
  parameter int DEPTH       = 4096,
  parameter int ALMOST_FULL = 3072
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     next_sample,
  input  logic [7:0]               sample_rate,
  input  logic                     mode_stereo,
  input  logic                     mode_16bit,
  input  logic                     capture_en,
  input  logic [15:0]              left_in,
  input  logic [15:0]              right_in,
  input  logic                     fifo_reset,
  input  logic                     fifo_read,
  output logic [7:0]               fifo_rddata,
  output logic                     fifo_empty,
  output logic                     fifo_almost_full,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(ALMOST_FULL);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_L_LO = 3'd1,
    W_L_HI = 3'd2,
    W_R_LO = 3'd3,
    W_R_HI = 3'd4
  } state_t;

`ifdef PCM_CAPTURE_ROUND_EN
  // Round the upper byte by the next bit down. 0x7F is held so that a
  // positive sample cannot wrap to negative. 0xFF + 1 = 0x00 is the correct
  // signed result, so that case is left to wrap.
  function automatic logic [7:0] sat_round(input logic [8:0] s);
    logic [7:0] res;
    if (s[0] && (s[8:1] == 8'h7F)) begin
      res = 8'h7F;
    end else begin
      res = s[8:1] + {7'd0, s[0]};
    end
    return res;
  endfunction
`endif

  // Rate accumulator and strobe generation
  logic [7:0] acc_r;
  logic       saved_bit_r;
  logic       tick_d_r;
  logic       strobe_s;

  // Step the accumulator on each base tick; remember the prior MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r       <= 8'd0;
      saved_bit_r <= 1'b0;
      tick_d_r    <= 1'b0;
    end else begin
      tick_d_r <= next_sample;
      if (next_sample) begin
        saved_bit_r <= acc_r[7];
        acc_r       <= acc_r + sample_rate;
      end
    end
  end

  // An MSB flip across the last tick means a capture is due this cycle
  assign strobe_s = tick_d_r & (acc_r[7] ^ saved_bit_r);

  // Frame holding registers and FSM
  state_t      state_r, state_nxt;
  logic [15:0] hold_l_r, hold_r_r;
  logic        hold_stereo_r, hold_16_r;
  logic        snap_s, drop_s, late_s, wr_en_s;
  logic [7:0]  wr_byte_s;
  logic [7:0]  l_byte8_s, r_byte8_s;
  logic [2:0]  frame_n_s;
  logic        room_s;

  logic [AW:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt, rd_ptr_nxt;
  logic [AW:0] count_r, count_nxt;
  logic        empty_r, full_r, afull_r;
  logic        pop_s;
  logic [7:0]  mem [DEPTH];
  logic [7:0]  rddata_r;
  logic        overflow_r;

`ifdef PCM_CAPTURE_ROUND_EN
  assign l_byte8_s = sat_round(hold_l_r[15:7]);
  assign r_byte8_s = sat_round(hold_r_r[15:7]);
`else
  assign l_byte8_s = hold_l_r[15:8];
  assign r_byte8_s = hold_r_r[15:8];
`endif

  // Frame size in bytes from the live mode bits; checked against free space
  always_comb begin
    case ({mode_stereo, mode_16bit})
      2'b00:   frame_n_s = 3'd1;
      2'b01:   frame_n_s = 3'd2;
      2'b10:   frame_n_s = 3'd2;
      2'b11:   frame_n_s = 3'd4;
      default: frame_n_s = 3'd4;
    endcase
  end

  assign room_s = ((DEPTH_C - count_r) >= (AW+1)'(frame_n_s));
  assign late_s = strobe_s && (state_r != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next state, FIFO write strobe and the byte to write
  always_comb begin
    state_nxt = state_r;
    snap_s    = 1'b0;
    drop_s    = 1'b0;
    wr_en_s   = 1'b0;
    wr_byte_s = 8'h00;
    if (fifo_reset) begin
      state_nxt = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (strobe_s && capture_en) begin
            snap_s = 1'b1;
            if (room_s) begin
              state_nxt = W_L_LO;
            end else begin
              drop_s    = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            state_nxt = IDLE;
          end
        end
        W_L_LO: begin
          wr_en_s   = 1'b1;
          wr_byte_s = hold_16_r ? hold_l_r[7:0] : l_byte8_s;
          if (hold_16_r) begin
            state_nxt = W_L_HI;
          end else if (hold_stereo_r) begin
            state_nxt = W_R_LO;
          end else begin
            state_nxt = IDLE;
          end
        end
        W_L_HI: begin
          wr_en_s   = 1'b1;
          wr_byte_s = hold_l_r[15:8];
          state_nxt = hold_stereo_r ? W_R_LO : IDLE;
        end
        W_R_LO: begin
          wr_en_s   = 1'b1;
          wr_byte_s = hold_16_r ? hold_r_r[7:0] : r_byte8_s;
          state_nxt = hold_16_r ? W_R_HI : IDLE;
        end
        W_R_HI: begin
          wr_en_s   = 1'b1;
          wr_byte_s = hold_r_r[15:8];
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Snapshot samples and modes when a frame is accepted or dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_l_r      <= 16'h0000;
      hold_r_r      <= 16'h0000;
      hold_stereo_r <= 1'b0;
      hold_16_r     <= 1'b0;
    end else if (snap_s) begin
      hold_l_r      <= left_in;
      hold_r_r      <= right_in;
      hold_stereo_r <= mode_stereo;
      hold_16_r     <= mode_16bit;
    end
  end

  // Sticky overflow; the FIFO clear takes priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (fifo_reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s || late_s) begin
      overflow_r <= 1'b1;
    end
  end

  // Pops are gated by the registered empty flag, which always tracks count_r
  assign pop_s = fifo_read && !empty_r && !fifo_reset;

  // Next pointers and the resulting count
  always_comb begin
    if (fifo_reset) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      wr_ptr_nxt = wr_ptr_r + (AW+1)'(wr_en_s);
      rd_ptr_nxt = rd_ptr_r + (AW+1)'(pop_s);
    end
    count_nxt = wr_ptr_nxt - rd_ptr_nxt;
  end

  // Pointers and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      afull_r  <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt;
      rd_ptr_r <= rd_ptr_nxt;
      count_r  <= count_nxt;
      empty_r  <= (count_nxt == '0);
      full_r   <= (count_nxt == DEPTH_C);
      afull_r  <= (count_nxt >= AF_C);
    end
  end

  // Byte storage
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_ptr_r[AW-1:0]] <= wr_byte_s;
    end
  end

  // Registered read data; holds when nothing is popped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rddata_r <= 8'h00;
    end else if (pop_s) begin
      rddata_r <= mem[rd_ptr_r[AW-1:0]];
    end
  end

  assign fifo_rddata      = rddata_r;
  assign fifo_empty       = empty_r;
  assign fifo_full        = full_r;
  assign fifo_almost_full = afull_r;
  assign fifo_count       = count_r;
  assign overflow         = overflow_r;

endmodule

// File: doc/pcm_capture.md
# pcm_capture

Audio capture path, mirroring PCM playback in reverse: samples the mixer's signed 16-bit stereo output at a programmable rate, packs each frame into bytes in the same layout playback consumes, and pushes them into an internal byte FIFO that the host drains through the register interface. A captured buffer can be replayed unchanged through the PCM playback path using the same mode settings.

## Interface
Parameters:
- DEPTH, 4096: FIFO size in bytes; power of two, ≥ 8.
- ALMOST_FULL, 3072: fifo_almost_full asserts when fifo_count ≥ this value.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- next_sample  in  1  single-cycle base-rate tick (48.828 kHz)
- sample_rate  in  8  rate accumulator increment; 0 = stopped, 128 = every tick
- mode_stereo  in  1  1 = capture left and right, 0 = left only
- mode_16bit  in  1  1 = 16-bit samples, 0 = 8-bit samples
- capture_en  in  1  enables starting new frames
- left_in, right_in  in  16 each  signed audio sources
- fifo_reset  in  1  synchronous FIFO clear
- fifo_read  in  1  host pop request
- fifo_rddata  out  8  popped byte
- fifo_empty, fifo_almost_full, fifo_full  out  1 each  FIFO status
- fifo_count  out  log2(DEPTH)+1  bytes held
- overflow  out  1  sticky: at least one frame dropped

## Operation
- Rate accumulator, 8 bits, reset 0: on next_sample, save acc[7] and acc <= acc + sample_rate. Capture strobe is asserted one cycle after next_sample when acc[7] differs from the saved bit. fifo_reset does not touch the accumulator.
- Frame size N = (mode_stereo ? 2 : 1) × (mode_16bit ? 2 : 1) bytes.
- States: IDLE, W_L_LO, W_L_HI, W_R_LO, W_R_HI.
- IDLE + strobe + capture_en: snapshot left_in, right_in, mode_stereo, mode_16bit into holding registers. If DEPTH − fifo_count ≥ N, go to the first write state. Otherwise drop the whole frame, set overflow, and stay in IDLE. Partial frames are never written.
- Write order: 16-bit frames write L[7:0], L[15:8], then R[7:0], R[15:8]. 8-bit frames write the L byte, then the R byte. One byte is written per cycle. After the last byte, return to IDLE.
- Held modes govern the frame. Register changes mid-frame take effect on the next frame.
- Strobe while not in IDLE: ignored and sets overflow. This cannot occur at legal clock ratios.
- capture_en low: no new frames start; a frame already in progress completes.
- 8-bit byte: upper byte of the sample (see Configuration).
- FIFO: circular, read and write pointers each log2(DEPTH)+1 bits.
  - Pop: fifo_read with fifo_empty=0 pops; fifo_rddata is registered and valid the cycle after fifo_read.
  - fifo_read while empty is ignored, and fifo_rddata holds.
  - Pop and write in the same cycle: both proceed, and fifo_count is unchanged.
- fifo_reset: pointers and count go to 0, overflow is cleared, and the state machine aborts to IDLE (a partial frame is discarded). It has priority over a read or write in the same cycle.

## Timing
- Reset values: state IDLE, acc 0, fifo_rddata 0, fifo_empty 1, fifo_full 0, fifo_almost_full 0, fifo_count 0, overflow 0.
- next_sample at cycle T: strobe at T+1, with inputs snapshotted at the T+1 edge. Bytes are written in cycles T+2 … T+1+N.
- Status outputs are registered: fifo_count, fifo_empty, fifo_full and fifo_almost_full reflect a write or pop from the following cycle. For the first byte, fifo_empty falls at T+3.
- overflow rises the cycle after the dropping strobe.
- Minimum clk/next_sample ratio ≥ N+2 = 6 cycles, so frames never overlap.

## Configuration
- PCM_CAPTURE_ROUND_EN defined: 8-bit byte = sample[15:8] + sample[7], saturating. 0x7F with sample[7]=1 stays 0x7F; 0xFF with sample[7]=1 becomes 0x00.
- Not defined: 8-bit byte = sample[15:8], truncated. 16-bit mode is unaffected either way.

## Test plan
- Reset, then sample_rate=128, 16-bit stereo, L=0x1234, R=0xABCD, one tick -> FIFO holds 34,12,CD,AB; fifo_count=4; pops return them in that order, each one cycle after its fifo_read.
- sample_rate=64, 8-bit mono, L=0x7F80, 8 ticks -> exactly 4 bytes. Each byte is 0x7F (with or without PCM_CAPTURE_ROUND_EN). Set L=0x1280: 0x13 with the macro, 0x12 without.
- Fill to DEPTH−3, then a 16-bit stereo frame -> nothing written, overflow=1, fifo_count unchanged. Pop 1 byte, capture again -> 4 bytes written, fifo_full=1.
- Host pops on every cycle during a 4-byte write -> fifo_count holds steady and data order is preserved. fifo_read while empty -> fifo_count stays 0 and fifo_rddata holds.
- fifo_reset asserted in W_L_HI -> count 0, overflow 0, state IDLE; the next frame writes a complete 4 bytes.
- Toggle capture_en low during W_R_LO -> the current frame completes with 4 bytes; subsequent ticks write nothing.
